// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending sequencer: state encoding, coin codes
// and the unit/greedy-change conversions used by the controller.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_e;

  localparam logic [1:0] COIN_5   = 2'd0;
  localparam logic [1:0] COIN_10  = 2'd1;
  localparam logic [1:0] COIN_20  = 2'd2;
  localparam logic [1:0] COIN_INV = 2'd3;

  // Credit is kept in 5-cent units; an invalid code is worth nothing.
  function automatic logic [2:0] coin_units(input logic [1:0] code);
    case (code)
      COIN_5:  coin_units = 3'd1;
      COIN_10: coin_units = 3'd2;
      COIN_20: coin_units = 3'd4;
      default: coin_units = 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] change_coin(input logic [7:0] units);
    if (units >= 8'd4)      change_coin = COIN_20;
    else if (units >= 8'd2) change_coin = COIN_10;
    else                    change_coin = COIN_5;
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter for the dispense timeout; expired is high once the
// count has run down to zero.
module vend_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: coin credit, price check, dispenser req/ack handshake
// with timeout, and greedy coin-by-coin change return.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned CREDIT_MAX = 40,
  parameter int unsigned PRICE0     = 3,
  parameter int unsigned PRICE1     = 4,
  parameter int unsigned PRICE2     = 5,
  parameter int unsigned PRICE3     = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                chg_ack,
  output logic                disp_req,
  output logic [1:0]          disp_id,
  output logic                chg_req,
  output logic [1:0]          chg_val,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                coin_reject,
  output logic                err_funds,
  output logic                fault
);

  localparam int unsigned       TIMER_W  = $clog2(TIMEOUT + 1);
  localparam logic [CREDIT_W:0] CMAX_EXT = (CREDIT_W + 1)'(CREDIT_MAX);

  function automatic logic [CREDIT_W:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    price_of = (CREDIT_W + 1)'(PRICE0);
      2'd1:    price_of = (CREDIT_W + 1)'(PRICE1);
      2'd2:    price_of = (CREDIT_W + 1)'(PRICE2);
      default: price_of = (CREDIT_W + 1)'(PRICE3);
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic [1:0]          disp_id_q, disp_id_d;
  logic                chg_req_q, chg_req_d;
  logic [1:0]          chg_val_q, chg_val_d;
  logic                coin_reject_q, coin_reject_d;
  logic                err_funds_q, err_funds_d;
  logic                fault_q, fault_d;
  logic                coin_ok;
  logic                tmr_clear, tmr_load, tmr_en, tmr_expired;

  // One extra bit of headroom so sums and differences never wrap.
  logic [CREDIT_W:0] credit_ext, coin_sum, sel_price, disp_price, restored;

  assign credit_ext = {1'b0, credit_q};
  assign coin_sum   = credit_ext + (CREDIT_W + 1)'(coin_units(coin_val));
  assign sel_price  = price_of(sel);
  assign disp_price = price_of(disp_id_q);
  assign restored   = credit_ext + disp_price;

  vend_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (tmr_clear),
    .load     (tmr_load),
    .load_val (TIMER_W'(TIMEOUT - 1)),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_req_d    = disp_req_q;
    disp_id_d     = disp_id_q;
    chg_req_d     = chg_req_q;
    chg_val_d     = chg_val_q;
    coin_reject_d = 1'b0;
    err_funds_d   = 1'b0;
    fault_d       = 1'b0;
    coin_ok       = 1'b0;
    tmr_clear     = 1'b0;
    tmr_load      = 1'b0;
    tmr_en        = 1'b0;

    case (state_q)
      S_IDLE, S_CREDIT: begin
        coin_ok = coin_valid;
        // Priority cancel > sel > coin; only an accepted cancel/sel consumes the coin slot.
        if (cancel && (state_q == S_CREDIT)) begin
          state_d   = S_CHANGE;
          chg_req_d = 1'b1;
          chg_val_d = change_coin(8'(credit_q));
          coin_ok   = 1'b0;
        end else if (sel_valid) begin
          if ((state_q == S_CREDIT) && (credit_ext >= sel_price)) begin
            state_d    = S_DISPENSE;
            credit_d   = CREDIT_W'(credit_ext - sel_price);
            disp_req_d = 1'b1;
            disp_id_d  = sel;
            tmr_load   = 1'b1;
            coin_ok    = 1'b0;
          end else begin
            err_funds_d = 1'b1;
          end
        end
        if (coin_ok) begin
          if ((coin_val != COIN_INV) && (coin_sum <= CMAX_EXT)) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (coin_valid) begin
          coin_reject_d = 1'b1;
        end
      end

      S_DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_ack) begin
          disp_req_d = 1'b0;
          tmr_clear  = 1'b1;
          if (credit_q != '0) begin
            state_d   = S_CHANGE;
            chg_req_d = 1'b1;
            chg_val_d = change_coin(8'(credit_q));
          end else begin
            state_d = S_IDLE;
          end
        end else if (tmr_expired) begin
          // Dispenser never answered: give the price back and refund everything.
          fault_d    = 1'b1;
          disp_req_d = 1'b0;
          tmr_clear  = 1'b1;
          credit_d   = restored[CREDIT_W-1:0];
          state_d    = S_CHANGE;
          chg_req_d  = 1'b1;
          chg_val_d  = change_coin(8'(restored));
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_req_q) begin
          if (chg_ack) begin
            credit_d  = CREDIT_W'(credit_ext - (CREDIT_W + 1)'(coin_units(chg_val_q)));
            chg_req_d = 1'b0;
          end
        end else if (credit_q == '0) begin
          state_d   = S_IDLE;
          chg_val_d = COIN_5;
        end else begin
          chg_req_d = 1'b1;
          chg_val_d = change_coin(8'(credit_q));
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      disp_id_q     <= 2'd0;
      chg_req_q     <= 1'b0;
      chg_val_q     <= 2'd0;
      coin_reject_q <= 1'b0;
      err_funds_q   <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      disp_id_q     <= disp_id_d;
      chg_req_q     <= chg_req_d;
      chg_val_q     <= chg_val_d;
      coin_reject_q <= coin_reject_d;
      err_funds_q   <= err_funds_d;
      fault_q       <= fault_d;
    end
  end

  assign disp_req    = disp_req_q;
  assign disp_id     = disp_id_q;
  assign chg_req     = chg_req_q;
  assign chg_val     = chg_val_q;
  assign credit      = credit_q;
  assign busy        = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
  assign coin_reject = coin_reject_q;
  assign err_funds   = err_funds_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: expected dispense ids and change coins are
// queued when stimulus is driven and compared when the DUT raises its requests.
module tb_vend_ctrl;

  logic       clk;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       sel_valid;
  logic [1:0] sel;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic [1:0] disp_id;
  logic       chg_req;
  logic [1:0] chg_val;
  logic [5:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       err_funds;
  logic       fault;

  int checks = 0;
  int errors = 0;
  int exp_disp_q[$];
  int exp_chg_q[$];

  vend_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .sel_valid   (sel_valid),
    .sel         (sel),
    .cancel      (cancel),
    .disp_ack    (disp_ack),
    .chg_ack     (chg_ack),
    .disp_req    (disp_req),
    .disp_id     (disp_id),
    .chg_req     (chg_req),
    .chg_val     (chg_val),
    .credit      (credit),
    .busy        (busy),
    .coin_reject (coin_reject),
    .err_funds   (err_funds),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic insert_coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_val   = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic press_sel(input logic [1:0] s);
    sel_valid = 1'b1;
    sel       = s;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic press_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  // Pops the expected product id, compares it, and optionally acknowledges.
  task automatic serve_dispense(input bit give_ack);
    int exp_id;
    for (int i = 0; i < 20 && !disp_req; i++) tick();
    exp_id = exp_disp_q.pop_front();
    checks++;
    if (disp_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL disp_req_wait: got %0b expected 1", disp_req);
      return;
    end
    checks++;
    if (disp_id !== 2'(exp_id)) begin
      errors++;
      $display("[TB] FAIL disp_id: got %0d expected %0d", disp_id, exp_id);
    end
    if (give_ack) begin
      disp_ack = 1'b1;
      tick();
      disp_ack = 1'b0;
      checks++;
      if (disp_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL disp_req_drop: got %0b expected 0", disp_req);
      end
    end
  endtask

  // Drains the expected change coins, then checks the return to idle.
  task automatic serve_change();
    int exp_c;
    while (exp_chg_q.size() > 0) begin
      for (int i = 0; i < 20 && !chg_req; i++) tick();
      exp_c = exp_chg_q.pop_front();
      checks++;
      if (chg_req !== 1'b1) begin
        errors++;
        $display("[TB] FAIL chg_req_wait: got %0b expected 1", chg_req);
        exp_chg_q.delete();
        return;
      end
      checks++;
      if (chg_val !== 2'(exp_c)) begin
        errors++;
        $display("[TB] FAIL chg_val: got %0d expected %0d", chg_val, exp_c);
      end
      chg_ack = 1'b1;
      tick();
      chg_ack = 1'b0;
      checks++;
      if (chg_req !== 1'b0) begin
        errors++;
        $display("[TB] FAIL chg_bubble: got %0b expected 0", chg_req);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL change_idle: got busy=%0b credit=%0d expected busy=0 credit=0", busy, credit);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (credit !== 6'd0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got credit=%0d busy=%0b expected 0/0", credit, busy);
    end
    checks++;
    if ({disp_req, chg_req, coin_reject, err_funds, fault} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000",
               {disp_req, chg_req, coin_reject, err_funds, fault});
    end
    checks++;
    if (disp_id !== 2'd0 || chg_val !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_ids: got disp_id=%0d chg_val=%0d expected 0/0", disp_id, chg_val);
    end
  endtask

  task automatic test_dispense();
    do_reset();
    insert_coin(2'd2);
    insert_coin(2'd1);
    checks++;
    if (credit !== 6'd6) begin
      errors++;
      $display("[TB] FAIL dispense_credit_in: got %0d expected 6", credit);
    end
    exp_disp_q.push_back(1);
    press_sel(2'd1);
    checks++;
    if (credit !== 6'd2 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dispense_debit: got credit=%0d busy=%0b expected 2/1", credit, busy);
    end
    serve_dispense(1'b1);
    exp_chg_q.push_back(1);
    serve_change();
  endtask

  task automatic test_err_funds();
    do_reset();
    press_sel(2'd0);
    checks++;
    if (err_funds !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_funds_idle: got %0b expected 1", err_funds);
    end
    insert_coin(2'd1);
    press_sel(2'd3);
    checks++;
    if (err_funds !== 1'b1 || credit !== 6'd2 || disp_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_funds_low: got err=%0b credit=%0d req=%0b expected 1/2/0",
               err_funds, credit, disp_req);
    end
    tick();
    checks++;
    if (err_funds !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_funds_pulse: got %0b expected 0", err_funds);
    end
    exp_chg_q.push_back(1);
    press_cancel();
    serve_change();
  endtask

  task automatic test_credit_limit();
    do_reset();
    for (int i = 0; i < 9; i++) insert_coin(2'd2);
    insert_coin(2'd1);
    insert_coin(2'd2);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 6'd38) begin
      errors++;
      $display("[TB] FAIL limit_reject: got rej=%0b credit=%0d expected 1/38", coin_reject, credit);
    end
    insert_coin(2'd1);
    checks++;
    if (coin_reject !== 1'b0 || credit !== 6'd40) begin
      errors++;
      $display("[TB] FAIL limit_fill: got rej=%0b credit=%0d expected 0/40", coin_reject, credit);
    end
    insert_coin(2'd3);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 6'd40) begin
      errors++;
      $display("[TB] FAIL invalid_coin: got rej=%0b credit=%0d expected 1/40", coin_reject, credit);
    end
    for (int i = 0; i < 10; i++) exp_chg_q.push_back(2);
    press_cancel();
    serve_change();
  endtask

  task automatic test_cancel_change();
    do_reset();
    press_cancel();
    checks++;
    if (busy !== 1'b0 || chg_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cancel_idle: got busy=%0b chg_req=%0b expected 0/0", busy, chg_req);
    end
    insert_coin(2'd2);
    insert_coin(2'd1);
    insert_coin(2'd0);
    exp_chg_q.push_back(2);
    exp_chg_q.push_back(1);
    exp_chg_q.push_back(0);
    press_cancel();
    serve_change();
  endtask

  task automatic test_timeout();
    int n_high;
    do_reset();
    insert_coin(2'd2);
    insert_coin(2'd0);
    exp_disp_q.push_back(0);
    press_sel(2'd0);
    serve_dispense(1'b0);
    n_high = 0;
    for (int i = 0; i < 300; i++) begin
      if (disp_req) n_high++;
      if (fault) break;
      tick();
    end
    checks++;
    if (fault !== 1'b1 || n_high != 255) begin
      errors++;
      $display("[TB] FAIL timeout_fault: got fault=%0b req_cycles=%0d expected 1/255", fault, n_high);
    end
    checks++;
    if (credit !== 6'd5 || disp_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_restore: got credit=%0d req=%0b expected 5/0", credit, disp_req);
    end
    exp_chg_q.push_back(2);
    exp_chg_q.push_back(0);
    serve_change();
  endtask

  task automatic test_back_to_back();
    do_reset();
    insert_coin(2'd2);
    exp_disp_q.push_back(1);
    coin_valid = 1'b1;
    coin_val   = 2'd1;
    sel_valid  = 1'b1;
    sel        = 2'd1;
    tick();
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    checks++;
    if (coin_reject !== 1'b1 || credit !== 6'd0) begin
      errors++;
      $display("[TB] FAIL same_cycle: got rej=%0b credit=%0d expected 1/0", coin_reject, credit);
    end
    serve_dispense(1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL same_cycle_idle: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_change();
    do_reset();
    insert_coin(2'd2);
    insert_coin(2'd1);
    press_cancel();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (credit !== 6'd0 || chg_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_change: got credit=%0d chg_req=%0b busy=%0b expected 0/0/0",
               credit, chg_req, busy);
    end
  endtask

  initial begin
    rst        = 1'b0;
    coin_valid = 1'b0;
    coin_val   = 2'd0;
    sel_valid  = 1'b0;
    sel        = 2'd0;
    cancel     = 1'b0;
    disp_ack   = 1'b0;
    chg_ack    = 1'b0;
    test_reset();
    test_dispense();
    test_err_funds();
    test_credit_limit();
    test_cancel_change();
    test_timeout();
    test_back_to_back();
    test_reset_mid_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
